// File: rtl/mist1032isa_mem_pkg.sv
// Purpose : shared types and helpers for the memory-bus requester (order codes, read tag, lane masks).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: order_e, tag_t, lane-mask constants, and the alignment, mask, write-data and extraction helpers.
package mist1032isa_mem_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  // One outstanding read: where the data sits in the beat and how to extend it.
  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] order;
    logic       sign_ext;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  localparam logic [3:0] MASK_LANE0 = 4'b0001;
  localparam logic [3:0] MASK_LO    = 4'b0011;
  localparam logic [3:0] MASK_HI    = 4'b1100;
  localparam logic [3:0] MASK_ALL   = 4'b1111;

  function automatic logic is_misaligned(input logic [1:0] order, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (order_e'(order))
      ORDER_HALF: bad = lane[0];
      ORDER_WORD: bad = |lane;
      ORDER_NONE: bad = 1'b1;
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] calc_mask(input logic [1:0] order, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (order_e'(order))
      ORDER_BYTE: m = 4'(MASK_LANE0 << lane);
      ORDER_HALF: m = lane[1] ? MASK_HI : MASK_LO;
      ORDER_WORD: m = MASK_ALL;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate narrow store data so it lands on whichever lanes the mask enables.
  function automatic logic [31:0] calc_wdata(input logic [1:0] order, input logic [31:0] dat);
    logic [31:0] w;
    w = dat;
    case (order_e'(order))
      ORDER_BYTE: w = {4{dat[7:0]}};
      ORDER_HALF: w = {2{dat[15:0]}};
      default:    w = dat;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] beat, input tag_t t);
    logic [31:0] w;
    logic [31:0] sh;
    logic [15:0] h;
    logic [31:0] r;
    w  = t.addr[2] ? beat[63:32] : beat[31:0];
    sh = w >> {t.addr[1:0], 3'b000};
    h  = t.addr[1] ? w[31:16] : w[15:0];
    r  = 32'h0;
    case (order_e'(t.order))
      ORDER_BYTE: r = {{24{t.sign_ext & sh[7]}}, sh[7:0]};
      ORDER_HALF: r = {{16{t.sign_ext & h[15]}}, h};
      ORDER_WORD: r = w;
      default:    r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mist1032isa_mem_master_tag_fifo.sv
// Purpose : in-order FIFO of read tags, synchronous active-high reset, depth a power of two.
// Latency : push visible at head the cycle after the write; pop advances head next cycle.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps the count.
// Ports   : clk_i, rst_i, push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o, count_o.
module mist1032isa_mem_master_tag_fifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 6,
  localparam int AW     = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1,
  localparam int CW     = AW + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [P_WIDTH-1:0] push_dat_i,
  input  logic               pop_i,
  output logic [P_WIDTH-1:0] head_dat_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CW-1:0]      count_o
);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o     = (count_q == CW'(P_DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/mist1032isa_mem_access_master.sv
// Purpose : bridges core byte/half/word loads and stores onto the registered memory-bus requester port.
// Latency : accept N -> oMEMORY_REQ at N+1; iMEMORY_VALID at M -> oRESP_VALID at M+1; 1 request/cycle.
// Backpressure: oREQ_BUSY while a request is pending and not issuing; oMEMORY_LOCK while slot full and iRESP_BUSY.
// Ports   : iCLOCK/iRESET_SYNC; core side iREQ_*/oREQ_BUSY, oRESP_*/iRESP_BUSY, oERR_MISALIGN;
//           bus side oMEMORY_REQ/ORDER/MASK/RW/ADDR/DATA, iMEMORY_LOCK, iMEMORY_VALID/DATA, oMEMORY_LOCK.
// Config  : define MIST1032ISA_MEM_MASTER_SIGN_EXT_EN to honour iREQ_SIGNED on byte/half loads.
module mist1032isa_mem_access_master
  import mist1032isa_mem_pkg::*;
#(
  parameter int P_OUTSTANDING = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic        iREQ_RW,
  input  logic [1:0]  iREQ_ORDER,
  input  logic        iREQ_SIGNED,
  input  logic [31:0] iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  output logic        oRESP_VALID,
  input  logic        iRESP_BUSY,
  output logic [31:0] oRESP_DATA,
  output logic        oERR_MISALIGN,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [25:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_LOCK,
  input  logic [63:0] iMEMORY_DATA
);

  localparam int CNT_W = ((P_OUTSTANDING > 1) ? $clog2(P_OUTSTANDING) : 1) + 1;

  logic        pend_q, pend_d;
  logic        rw_q, rw_d;
  logic [1:0]  order_q, order_d;
  logic [3:0]  mask_q, mask_d;
  logic [25:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic        resp_vld_q, resp_vld_d;
  logic [31:0] resp_dat_q, resp_dat_d;

  logic             accept, misalign, load_req, issue_now, req_sign;
  logic             tag_push, tag_pop;
  tag_t             tag_push_dat, tag_head;
  logic [TAG_W-1:0] tag_head_raw;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_bits;

`ifdef MIST1032ISA_MEM_MASTER_SIGN_EXT_EN
  assign req_sign    = iREQ_SIGNED;
  assign unused_bits = ^{iREQ_ADDR[31:26], fifo_count};
`else
  // Without sign extension the tag bit is tied low so every load zero-extends.
  assign req_sign    = 1'b0;
  assign unused_bits = ^{iREQ_ADDR[31:26], fifo_count, iREQ_SIGNED};
`endif

  // A read is withheld from the bus until the tag FIFO can record it; writes never wait on it.
  assign oMEMORY_REQ = pend_q && (rw_q || !fifo_full);
  assign issue_now   = oMEMORY_REQ && !iMEMORY_LOCK;
  assign oREQ_BUSY   = pend_q && !issue_now;

  assign accept   = iREQ_VALID && !oREQ_BUSY;
  assign misalign = is_misaligned(iREQ_ORDER, iREQ_ADDR[1:0]);
  assign load_req = accept && !misalign;

  assign tag_push     = issue_now && !rw_q;
  assign tag_push_dat = '{addr: addr_q[2:0], order: order_q, sign_ext: sign_q};
  // Beats with no outstanding tag are strays and must not disturb the slot.
  assign tag_pop      = iMEMORY_VALID && !fifo_empty;
  assign tag_head     = tag_t'(tag_head_raw);

  mist1032isa_mem_master_tag_fifo #(
    .P_DEPTH (P_OUTSTANDING),
    .P_WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk_i      (iCLOCK),
    .rst_i      (iRESET_SYNC),
    .push_i     (tag_push),
    .push_dat_i (tag_push_dat),
    .pop_i      (tag_pop),
    .head_dat_o (tag_head_raw),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    pend_d     = pend_q;
    rw_d       = rw_q;
    order_d    = order_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    sign_d     = sign_q;
    err_d      = accept && misalign;
    resp_vld_d = resp_vld_q;
    resp_dat_d = resp_dat_q;

    // A new accept in the issuing cycle refills the register back-to-back.
    if (load_req) begin
      pend_d  = 1'b1;
      rw_d    = iREQ_RW;
      order_d = iREQ_ORDER;
      mask_d  = calc_mask(iREQ_ORDER, iREQ_ADDR[1:0]);
      addr_d  = iREQ_ADDR[25:0];
      wdat_d  = calc_wdata(iREQ_ORDER, iREQ_DATA);
      sign_d  = req_sign;
    end else if (issue_now) begin
      pend_d = 1'b0;
    end

    if (tag_pop) begin
      resp_vld_d = 1'b1;
      resp_dat_d = extract(iMEMORY_DATA, tag_head);
    end else if (resp_vld_q && !iRESP_BUSY) begin
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      pend_q     <= 1'b0;
      rw_q       <= 1'b0;
      order_q    <= 2'b00;
      mask_q     <= 4'b0000;
      addr_q     <= '0;
      wdat_q     <= '0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_dat_q <= '0;
    end else begin
      pend_q     <= pend_d;
      rw_q       <= rw_d;
      order_q    <= order_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
    end
  end

  assign oMEMORY_ORDER = order_q;
  assign oMEMORY_MASK  = mask_q;
  assign oMEMORY_RW    = rw_q;
  assign oMEMORY_ADDR  = addr_q;
  assign oMEMORY_DATA  = wdat_q;
  assign oERR_MISALIGN = err_q;
  assign oRESP_VALID   = resp_vld_q;
  assign oRESP_DATA    = resp_dat_q;
  assign oMEMORY_LOCK  = resp_vld_q && iRESP_BUSY;

endmodule

// File: tb/tb_mist1032isa_mem_access_master.sv
// Directed bench for the memory-bus requester: stores, loads, misalignment, LOCK stall,
// outstanding limit, response back-pressure, stray beats and mid-stream reset.
module tb_mist1032isa_mem_access_master;
  import mist1032isa_mem_pkg::*;

`ifdef MIST1032ISA_MEM_MASTER_SIGN_EXT_EN
  localparam logic [31:0] EXP_HALF_S = 32'hFFFF8001;
  localparam logic [31:0] EXP_BYTE_S = 32'hFFFFFF88;
`else
  localparam logic [31:0] EXP_HALF_S = 32'h00008001;
  localparam logic [31:0] EXP_BYTE_S = 32'h00000088;
`endif

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iREQ_VALID, iREQ_RW, iREQ_SIGNED;
  logic [1:0]  iREQ_ORDER;
  logic [31:0] iREQ_ADDR, iREQ_DATA;
  logic        iRESP_BUSY, iMEMORY_LOCK, iMEMORY_VALID;
  logic [63:0] iMEMORY_DATA;
  logic        oREQ_BUSY, oRESP_VALID, oERR_MISALIGN, oMEMORY_REQ, oMEMORY_RW, oMEMORY_LOCK;
  logic [31:0] oRESP_DATA, oMEMORY_DATA;
  logic [1:0]  oMEMORY_ORDER;
  logic [3:0]  oMEMORY_MASK;
  logic [25:0] oMEMORY_ADDR;

  int tests = 0;
  int fails = 0;

  always #5 iCLOCK = ~iCLOCK;

  mist1032isa_mem_access_master #(.P_OUTSTANDING(4)) dut (
    .iCLOCK        (iCLOCK),
    .iRESET_SYNC   (iRESET_SYNC),
    .iREQ_VALID    (iREQ_VALID),
    .oREQ_BUSY     (oREQ_BUSY),
    .iREQ_RW       (iREQ_RW),
    .iREQ_ORDER    (iREQ_ORDER),
    .iREQ_SIGNED   (iREQ_SIGNED),
    .iREQ_ADDR     (iREQ_ADDR),
    .iREQ_DATA     (iREQ_DATA),
    .oRESP_VALID   (oRESP_VALID),
    .iRESP_BUSY    (iRESP_BUSY),
    .oRESP_DATA    (oRESP_DATA),
    .oERR_MISALIGN (oERR_MISALIGN),
    .oMEMORY_REQ   (oMEMORY_REQ),
    .iMEMORY_LOCK  (iMEMORY_LOCK),
    .oMEMORY_ORDER (oMEMORY_ORDER),
    .oMEMORY_MASK  (oMEMORY_MASK),
    .oMEMORY_RW    (oMEMORY_RW),
    .oMEMORY_ADDR  (oMEMORY_ADDR),
    .oMEMORY_DATA  (oMEMORY_DATA),
    .iMEMORY_VALID (iMEMORY_VALID),
    .oMEMORY_LOCK  (oMEMORY_LOCK),
    .iMEMORY_DATA  (iMEMORY_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] ord, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] dat);
    iREQ_VALID  = 1'b1;
    iREQ_RW     = rw;
    iREQ_ORDER  = ord;
    iREQ_SIGNED = sgn;
    iREQ_ADDR   = addr;
    iREQ_DATA   = dat;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({oREQ_BUSY, oRESP_VALID, oERR_MISALIGN, oMEMORY_REQ, oMEMORY_ORDER,
                            oMEMORY_MASK, oMEMORY_RW, oMEMORY_LOCK}), 32'h0);
    chk({tag, "_rdata"}, oRESP_DATA, 32'h0);
    chk({tag, "_addr"}, 32'(oMEMORY_ADDR), 32'h0);
    chk({tag, "_wdata"}, oMEMORY_DATA, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRESET_SYNC = 1'b1; iREQ_VALID = 1'b0; iREQ_RW = 1'b0; iREQ_ORDER = 2'b00;
    iREQ_SIGNED = 1'b0; iREQ_ADDR = 32'h0; iREQ_DATA = 32'h0; iRESP_BUSY = 1'b0;
    iMEMORY_LOCK = 1'b0; iMEMORY_VALID = 1'b0; iMEMORY_DATA = 64'h0;

    // Reset state
    step(); step(); #2;
    chk_all_zero("reset");

    // Byte store 0xA5 at 0x103
    step(); iRESET_SYNC = 1'b0; drive(1'b1, ORDER_BYTE, 1'b0, 32'h103, 32'hA5); #2;
    chk("st_busy", 32'(oREQ_BUSY), 32'h0);
    step(); iREQ_VALID = 1'b0; #2;
    chk("st_req", 32'(oMEMORY_REQ), 32'h1);
    chk("st_mask", 32'(oMEMORY_MASK), 32'h8);
    chk("st_data", oMEMORY_DATA, 32'hA5A5A5A5);
    chk("st_addr", 32'(oMEMORY_ADDR), 32'h103);
    chk("st_rw", 32'(oMEMORY_RW), 32'h1);
    step(); #2;
    chk("st_req_done", 32'(oMEMORY_REQ), 32'h0);
    chk("st_noresp", 32'(oRESP_VALID), 32'h0);

    // Signed half load at 0x006
    step(); drive(1'b0, ORDER_HALF, 1'b1, 32'h006, 32'h0); #2;
    step(); iREQ_VALID = 1'b0; #2;
    chk("ldh_req", 32'(oMEMORY_REQ), 32'h1);
    chk("ldh_mask", 32'(oMEMORY_MASK), 32'hC);
    chk("ldh_rw", 32'(oMEMORY_RW), 32'h0);
    step(); iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h8001_0000_0000_0000; #2;
    chk("ldh_not_yet", 32'(oRESP_VALID), 32'h0);
    step(); iMEMORY_VALID = 1'b0; #2;
    chk("ldh_vld", 32'(oRESP_VALID), 32'h1);
    chk("ldh_data", oRESP_DATA, EXP_HALF_S);
    step(); #2;
    chk("ldh_drained", 32'(oRESP_VALID), 32'h0);

    // Misaligned word load at 0x002
    step(); drive(1'b0, ORDER_WORD, 1'b0, 32'h002, 32'h0); #2;
    step(); iREQ_VALID = 1'b0; #2;
    chk("mis_noreq", 32'(oMEMORY_REQ), 32'h0);
    chk("mis_err", 32'(oERR_MISALIGN), 32'h1);
    step(); #2;
    chk("mis_err_pulse", 32'(oERR_MISALIGN), 32'h0);
    chk("mis_noreq2", 32'(oMEMORY_REQ), 32'h0);

    // LOCK stall for three cycles on a word read at 0x00C
    step(); drive(1'b0, ORDER_WORD, 1'b0, 32'h00C, 32'h0); iMEMORY_LOCK = 1'b1; #2;
    for (int i = 0; i < 3; i++) begin
      step(); iREQ_VALID = 1'b0; #2;
      chk("lk_req", 32'(oMEMORY_REQ), 32'h1);
      chk("lk_busy", 32'(oREQ_BUSY), 32'h1);
      chk("lk_addr", 32'(oMEMORY_ADDR), 32'h00C);
      chk("lk_mask", 32'(oMEMORY_MASK), 32'hF);
    end
    step(); iMEMORY_LOCK = 1'b0; #2;
    chk("lk_issue_req", 32'(oMEMORY_REQ), 32'h1);
    chk("lk_issue_busy", 32'(oREQ_BUSY), 32'h0);
    step(); #2;
    chk("lk_issued", 32'(oMEMORY_REQ), 32'h0);

    // Response back-pressure: slot full and core busy
    step(); iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h11223344_55667788; iRESP_BUSY = 1'b1; #2;
    step(); iMEMORY_VALID = 1'b0; #2;
    chk("bp_vld", 32'(oRESP_VALID), 32'h1);
    chk("bp_data", oRESP_DATA, 32'h11223344);
    chk("bp_lock", 32'(oMEMORY_LOCK), 32'h1);
    step(); #2;
    chk("bp_hold_vld", 32'(oRESP_VALID), 32'h1);
    chk("bp_hold_data", oRESP_DATA, 32'h11223344);
    step(); iRESP_BUSY = 1'b0; #2;
    chk("bp_unlock", 32'(oMEMORY_LOCK), 32'h0);
    step(); #2;
    chk("bp_drained", 32'(oRESP_VALID), 32'h0);

    // Outstanding limit: five back-to-back reads, no beats
    step(); drive(1'b0, ORDER_WORD, 1'b0, 32'h20, 32'h0); #2;
    chk("ol_acc0", 32'(oREQ_BUSY), 32'h0);
    step(); drive(1'b0, ORDER_BYTE, 1'b0, 32'h21, 32'h0); #2;
    chk("ol_acc1", 32'(oREQ_BUSY), 32'h0);
    step(); drive(1'b0, ORDER_HALF, 1'b0, 32'h22, 32'h0); #2;
    step(); drive(1'b0, ORDER_BYTE, 1'b1, 32'h27, 32'h0); #2;
    step(); drive(1'b0, ORDER_WORD, 1'b0, 32'h24, 32'h0); #2;
    chk("ol_acc4", 32'(oREQ_BUSY), 32'h0);
    step(); iREQ_VALID = 1'b0; #2;
    chk("ol_held_req", 32'(oMEMORY_REQ), 32'h0);
    chk("ol_held_busy", 32'(oREQ_BUSY), 32'h1);
    chk("ol_held_addr", 32'(oMEMORY_ADDR), 32'h24);
    step(); #2;
    chk("ol_held_req2", 32'(oMEMORY_REQ), 32'h0);
    step(); iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h8899AABB_CCDDEEFF; #2;
    chk("ol_beat_req", 32'(oMEMORY_REQ), 32'h0);
    step(); #2;
    chk("ol_r0_vld", 32'(oRESP_VALID), 32'h1);
    chk("ol_r0_data", oRESP_DATA, 32'hCCDDEEFF);
    chk("ol_fifth_req", 32'(oMEMORY_REQ), 32'h1);
    step(); #2;
    chk("ol_r1_data", oRESP_DATA, 32'h000000EE);
    chk("ol_fifth_gone", 32'(oMEMORY_REQ), 32'h0);
    step(); #2;
    chk("ol_r2_data", oRESP_DATA, 32'h0000CCDD);
    step(); #2;
    chk("ol_r3_data", oRESP_DATA, EXP_BYTE_S);
    step(); iMEMORY_VALID = 1'b0; #2;
    chk("ol_r4_data", oRESP_DATA, 32'h8899AABB);

    // Stray beat with no outstanding reads
    step(); iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'hFFFF_FFFF_FFFF_FFFF; #2;
    step(); iMEMORY_VALID = 1'b0; #2;
    chk("stray_vld", 32'(oRESP_VALID), 32'h0);

    // Reset mid-stream with a held request and a full, busy slot
    step(); drive(1'b0, ORDER_WORD, 1'b0, 32'h30, 32'h0); #2;
    step(); drive(1'b0, ORDER_WORD, 1'b0, 32'h34, 32'h0); #2;
    step(); iREQ_VALID = 1'b0; iMEMORY_LOCK = 1'b1; iRESP_BUSY = 1'b1;
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'hDEADBEEF_CAFEF00D; #2;
    chk("rs_req", 32'(oMEMORY_REQ), 32'h1);
    chk("rs_busy", 32'(oREQ_BUSY), 32'h1);
    step(); iMEMORY_VALID = 1'b0; #2;
    chk("rs_slot", oRESP_DATA, 32'hCAFEF00D);
    chk("rs_lock", 32'(oMEMORY_LOCK), 32'h1);
    step(); iRESET_SYNC = 1'b1; #2;
    step(); #2;
    chk_all_zero("rs_mid");
    step(); iRESET_SYNC = 1'b0; iMEMORY_LOCK = 1'b0; iRESP_BUSY = 1'b0;
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h12345678_9ABCDEF0; #2;
    chk("rs_req_dropped", 32'(oMEMORY_REQ), 32'h0);
    step(); iMEMORY_VALID = 1'b0; #2;
    chk("rs_beat_discarded", 32'(oRESP_VALID), 32'h0);
    chk("rs_req_still_0", 32'(oMEMORY_REQ), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
